// File: rtl/cpu_pkg.sv
// Shared LEGv8 pipeline types: widths, zero register, forward-select codes, ID/EX control.
package cpu_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CTRL_W = 16;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd31;

    typedef enum logic [2:0] {
        FWD_RF,
        FWD_WB,
        FWD_MEM,
        FWD_EX,
        FWD_ZERO
    } fwd_sel_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic [REG_AW-1:0] rd;
        logic [CTRL_W-1:0] ctrl;
    } idex_ctrl_t;

    // True when an enabled producer writes the given source; X31 never matches.
    function automatic logic reg_hit(input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] src,
                                     input logic              en);
        return en && (rd == src) && (src != REG_ZERO);
    endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// ID-side bus of the operand fetch stage: ID inputs, regfile data, producers, ID/EX outputs.
interface operand_fetch_stage_if;
    import cpu_pkg::*;

    logic              id_valid;
    logic [REG_AW-1:0] id_rn;
    logic [REG_AW-1:0] id_rm;
    logic              id_uses_rn;
    logic              id_uses_rm;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic [DATA_W-1:0] id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic [DATA_W-1:0] ex_result;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_reg_write;
    logic [DATA_W-1:0] mem_result;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_reg_write;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              id_stall;
    logic              ex_valid;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_op_a;
    logic [DATA_W-1:0] ex_op_b;
    logic [DATA_W-1:0] ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;

    modport master (
        output id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_rd, id_reg_write,
               id_mem_read, id_imm, id_ctrl, rd_data1, rd_data2, ex_result,
               mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_data, flush,
        input  id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_op_a, ex_op_b,
               ex_imm, ex_ctrl
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_rd, id_reg_write,
               id_mem_read, id_imm, id_ctrl, rd_data1, rd_data2, ex_result,
               mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_data, flush,
        output id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_op_a, ex_op_b,
               ex_imm, ex_ctrl
    );

endinterface

// File: rtl/operand_fwd_mux.sv
// Per-source operand selector with hazard detection.
// OPERAND_FWD_EN defined: EX/MEM/WB forwarding, stall only on load-use.
// OPERAND_FWD_EN undefined: regfile only, stall on any in-flight writer of the source.
module operand_fwd_mux
    import cpu_pkg::*;
(
    input  logic [REG_AW-1:0] src_i,
    input  logic              uses_i,
    input  logic              ex_valid_i,
    input  logic              ex_reg_write_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [DATA_W-1:0] ex_result_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_reg_write_i,
    input  logic [DATA_W-1:0] mem_result_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_reg_write_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output fwd_sel_t          sel_c_o,
    output logic [DATA_W-1:0] val_c_o,
    output logic              hazard_c_o
);

    logic ex_hit_c;
    logic mem_hit_c;
    logic wb_hit_c;

    // Producer matches; X31 is excluded inside reg_hit.
    always_comb begin
        ex_hit_c  = reg_hit(ex_rd_i, src_i, ex_valid_i & ex_reg_write_i);
        mem_hit_c = reg_hit(mem_rd_i, src_i, mem_reg_write_i);
        wb_hit_c  = reg_hit(wb_rd_i, src_i, wb_reg_write_i);
    end

`ifdef OPERAND_FWD_EN
    // Youngest producer wins; a load in EX has no data yet so it is skipped and stalls instead.
    always_comb begin
        sel_c_o    = FWD_RF;
        val_c_o    = rd_data_i;
        hazard_c_o = uses_i & reg_hit(ex_rd_i, src_i, ex_valid_i & ex_mem_read_i);
        if (src_i == REG_ZERO) begin
            sel_c_o = FWD_ZERO;
        end else if (ex_hit_c && !ex_mem_read_i) begin
            sel_c_o = FWD_EX;
        end else if (mem_hit_c) begin
            sel_c_o = FWD_MEM;
        end else if (wb_hit_c) begin
            sel_c_o = FWD_WB;
        end
        case (sel_c_o)
            FWD_ZERO: val_c_o = '0;
            FWD_EX:   val_c_o = ex_result_i;
            FWD_MEM:  val_c_o = mem_result_i;
            FWD_WB:   val_c_o = wb_data_i;
            default:  val_c_o = rd_data_i;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex_result_i, mem_result_i, wb_data_i, ex_mem_read_i};

    // No bypass: wait until the value has been written back to the regfile.
    always_comb begin
        sel_c_o    = FWD_RF;
        val_c_o    = rd_data_i;
        hazard_c_o = uses_i & (ex_hit_c | mem_hit_c | wb_hit_c);
        if (src_i == REG_ZERO) begin
            sel_c_o = FWD_ZERO;
            val_c_o = '0;
        end
    end
`endif

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: operand forwarding/stall control and the ID/EX pipeline register.
// Forwarding is built in when OPERAND_FWD_EN is defined; otherwise hazards stall until writeback.
module operand_fetch_stage
    import cpu_pkg::*;
(
    input logic                  clk,
    input logic                  reset,
    operand_fetch_stage_if.slave bus
);

    idex_ctrl_t        ctl_q;
    idex_ctrl_t        ctl_d;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_a_d;
    logic [DATA_W-1:0] op_b_q;
    logic [DATA_W-1:0] op_b_d;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] imm_d;

    fwd_sel_t          sel_a_c;
    fwd_sel_t          sel_b_c;
    logic [DATA_W-1:0] val_a_c;
    logic [DATA_W-1:0] val_b_c;
    logic              hz_a_c;
    logic              hz_b_c;
    logic              id_stall_c;
    logic              bubble_c;

    // Select codes are kept for debug visibility only.
    logic unused_sel;
    assign unused_sel = ^{sel_a_c, sel_b_c};

    operand_fwd_mux u_mux_rn (
        .src_i           (bus.id_rn),
        .uses_i          (bus.id_uses_rn),
        .ex_valid_i      (ctl_q.valid),
        .ex_reg_write_i  (ctl_q.reg_write),
        .ex_mem_read_i   (ctl_q.mem_read),
        .ex_rd_i         (ctl_q.rd),
        .ex_result_i     (bus.ex_result),
        .mem_rd_i        (bus.mem_rd),
        .mem_reg_write_i (bus.mem_reg_write),
        .mem_result_i    (bus.mem_result),
        .wb_rd_i         (bus.wb_rd),
        .wb_reg_write_i  (bus.wb_reg_write),
        .wb_data_i       (bus.wb_data),
        .rd_data_i       (bus.rd_data1),
        .sel_c_o         (sel_a_c),
        .val_c_o         (val_a_c),
        .hazard_c_o      (hz_a_c)
    );

    operand_fwd_mux u_mux_rm (
        .src_i           (bus.id_rm),
        .uses_i          (bus.id_uses_rm),
        .ex_valid_i      (ctl_q.valid),
        .ex_reg_write_i  (ctl_q.reg_write),
        .ex_mem_read_i   (ctl_q.mem_read),
        .ex_rd_i         (ctl_q.rd),
        .ex_result_i     (bus.ex_result),
        .mem_rd_i        (bus.mem_rd),
        .mem_reg_write_i (bus.mem_reg_write),
        .mem_result_i    (bus.mem_result),
        .wb_rd_i         (bus.wb_rd),
        .wb_reg_write_i  (bus.wb_reg_write),
        .wb_data_i       (bus.wb_data),
        .rd_data_i       (bus.rd_data2),
        .sel_c_o         (sel_b_c),
        .val_c_o         (val_b_c),
        .hazard_c_o      (hz_b_c)
    );

    // Stall/bubble decision and next ID/EX contents; flush overrides a stall since IF/ID is redirected.
    always_comb begin
        id_stall_c      = 1'b0;
        bubble_c        = 1'b0;
        ctl_d           = '0;
        op_a_d          = val_a_c;
        op_b_d          = val_b_c;
        imm_d           = bus.id_imm;

        id_stall_c      = bus.id_valid & (hz_a_c | hz_b_c) & ~bus.flush;
        bubble_c        = bus.flush | ~bus.id_valid | hz_a_c | hz_b_c;

        ctl_d.valid     = ~bubble_c;
        ctl_d.reg_write = ~bubble_c & bus.id_reg_write;
        ctl_d.mem_read  = ~bubble_c & bus.id_mem_read;
        ctl_d.rd        = bus.id_rd;
        ctl_d.ctrl      = bus.id_ctrl;
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_q  <= '0;
            op_a_q <= '0;
            op_b_q <= '0;
            imm_q  <= '0;
        end else begin
            ctl_q  <= ctl_d;
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
            imm_q  <= imm_d;
        end
    end

    assign bus.id_stall     = id_stall_c;
    assign bus.ex_valid     = ctl_q.valid;
    assign bus.ex_reg_write = ctl_q.reg_write;
    assign bus.ex_mem_read  = ctl_q.mem_read;
    assign bus.ex_rd        = ctl_q.rd;
    assign bus.ex_ctrl      = ctl_q.ctrl;
    assign bus.ex_op_a      = op_a_q;
    assign bus.ex_op_b      = op_b_q;
    assign bus.ex_imm       = imm_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage; follows OPERAND_FWD_EN like the RTL.
module tb_operand_fetch_stage;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    operand_fetch_stage_if bus ();

    operand_fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        id_valid;
        logic [4:0]  rn, rm;
        logic        uses_rn, uses_rm;
        logic [4:0]  rd;
        logic        rw, mr;
        logic [63:0] imm;
        logic [15:0] ctrl;
        logic [63:0] d1, d2, exr;
        logic [4:0]  mem_rd;
        logic        mem_rw;
        logic [63:0] mem_res;
        logic [4:0]  wb_rd;
        logic        wb_rw;
        logic [63:0] wb_d;
        logic        flush;
    } stim_t;

    typedef struct {
        logic        valid, rw, mr;
        logic [4:0]  rd;
        logic [63:0] a, b, imm;
        logic [15:0] ctrl;
        logic        chk_a, chk_b;
    } exp_t;

    exp_t ex_q[$];
    bit   stall_q[$];
    bit   active = 1'b0;
    int   total = 0;
    int   bad = 0;

    // Reference view of the instruction sitting in EX (what the ID/EX register should hold).
    logic       m_valid = 1'b0, m_rw = 1'b0, m_mr = 1'b0;
    logic [4:0] m_rd = 5'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural value of a source as ID should see it.
    function automatic logic [63:0] see(input logic [4:0] src, input logic [63:0] rf, input stim_t s);
        if (src == 5'd31) return 64'd0;
`ifdef OPERAND_FWD_EN
        if (m_valid && m_rw && !m_mr && m_rd == src) return s.exr;
        if (s.mem_rw && s.mem_rd == src) return s.mem_res;
        if (s.wb_rw && s.wb_rd == src) return s.wb_d;
`endif
        return rf;
    endfunction

    // Whether this source cannot be served this cycle.
    function automatic logic waits(input logic [4:0] src, input logic used, input stim_t s);
        if (!used || src == 5'd31) return 1'b0;
`ifdef OPERAND_FWD_EN
        return m_valid && m_mr && m_rd == src;
`else
        return (m_valid && m_rw && m_rd == src) || (s.mem_rw && s.mem_rd == src) ||
               (s.wb_rw && s.wb_rd == src);
`endif
    endfunction

    task automatic apply(input stim_t s);
        bus.id_valid = s.id_valid;   bus.id_rn = s.rn;            bus.id_rm = s.rm;
        bus.id_uses_rn = s.uses_rn;  bus.id_uses_rm = s.uses_rm;  bus.id_rd = s.rd;
        bus.id_reg_write = s.rw;     bus.id_mem_read = s.mr;      bus.id_imm = s.imm;
        bus.id_ctrl = s.ctrl;        bus.rd_data1 = s.d1;         bus.rd_data2 = s.d2;
        bus.ex_result = s.exr;       bus.mem_rd = s.mem_rd;       bus.mem_reg_write = s.mem_rw;
        bus.mem_result = s.mem_res;  bus.wb_rd = s.wb_rd;         bus.wb_reg_write = s.wb_rw;
        bus.wb_data = s.wb_d;        bus.flush = s.flush;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{id_valid: 1'b0, rn: 5'd0, rm: 5'd0, uses_rn: 1'b0, uses_rm: 1'b0, rd: 5'd0,
              rw: 1'b0, mr: 1'b0, imm: 64'd0, ctrl: 16'd0, d1: 64'd0, d2: 64'd0, exr: 64'd0,
              mem_rd: 5'd0, mem_rw: 1'b0, mem_res: 64'd0, wb_rd: 5'd0, wb_rw: 1'b0,
              wb_d: 64'd0, flush: 1'b0};
        return s;
    endfunction

    function automatic logic [4:0] rreg();
        int unsigned r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s = idle();
        s.id_valid = ($urandom_range(0, 9) < 8);
        s.rn = rreg();  s.rm = rreg();  s.rd = rreg();
        s.uses_rn = ($urandom_range(0, 9) < 8);
        s.uses_rm = ($urandom_range(0, 9) < 8);
        s.rw = ($urandom_range(0, 9) < 7);
        s.mr = ($urandom_range(0, 9) < 3);
        s.imm = {$urandom, $urandom};  s.ctrl = 16'($urandom);
        s.d1 = {$urandom, $urandom};   s.d2 = {$urandom, $urandom};
        s.exr = {$urandom, $urandom};
        s.mem_rd = rreg();  s.mem_rw = ($urandom_range(0, 9) < 5);  s.mem_res = {$urandom, $urandom};
        s.wb_rd = rreg();   s.wb_rw = ($urandom_range(0, 9) < 5);   s.wb_d = {$urandom, $urandom};
        s.flush = ($urandom_range(0, 9) == 0);
        return s;
    endfunction

    // Drive one ID cycle and push the expected stall and ID/EX contents.
    task automatic step(input stim_t s);
        exp_t e;
        logic hz, stall, bubble;
        @(negedge clk);
        apply(s);
        hz     = waits(s.rn, s.uses_rn, s) || waits(s.rm, s.uses_rm, s);
        stall  = s.id_valid && hz && !s.flush;
        bubble = s.flush || !s.id_valid || hz;
        e.valid = !bubble;  e.rw = !bubble && s.rw;  e.mr = !bubble && s.mr;
        e.rd = s.rd;  e.imm = s.imm;  e.ctrl = s.ctrl;
        e.a = see(s.rn, s.d1, s);  e.b = see(s.rm, s.d2, s);
        e.chk_a = s.uses_rn;  e.chk_b = s.uses_rm;
        stall_q.push_back(stall);
        ex_q.push_back(e);
        m_valid = e.valid;  m_rw = e.rw;  m_mr = e.mr;  m_rd = s.rd;
        active = 1'b1;
    endtask

    // Monitor: ID/EX outputs after each active edge.
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (active && !reset) begin
            if (ex_q.size() == 0) begin
                chk("ex_queue_empty", 64'd1, 64'd0);
            end else begin
                e = ex_q.pop_front();
                chk("ex_valid", 64'(bus.ex_valid), 64'(e.valid));
                chk("ex_reg_write", 64'(bus.ex_reg_write), 64'(e.rw));
                chk("ex_mem_read", 64'(bus.ex_mem_read), 64'(e.mr));
                if (e.valid) begin
                    chk("ex_rd", 64'(bus.ex_rd), 64'(e.rd));
                    chk("ex_imm", bus.ex_imm, e.imm);
                    chk("ex_ctrl", 64'(bus.ex_ctrl), 64'(e.ctrl));
                    if (e.chk_a) chk("ex_op_a", bus.ex_op_a, e.a);
                    if (e.chk_b) chk("ex_op_b", bus.ex_op_b, e.b);
                end
            end
        end
    end

    // Monitor: combinational stall mid-cycle.
    initial forever begin
        bit st;
        @(negedge clk);
        #2;
        if (active && !reset) begin
            if (stall_q.size() == 0) begin
                chk("stall_queue_empty", 64'd1, 64'd0);
            end else begin
                st = stall_q.pop_front();
                chk("id_stall", 64'(bus.id_stall), 64'(st));
            end
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_ex_valid"}, 64'(bus.ex_valid), 64'd0);
        chk({tag, "_ex_rw"}, 64'(bus.ex_reg_write), 64'd0);
        chk({tag, "_ex_mr"}, 64'(bus.ex_mem_read), 64'd0);
        chk({tag, "_ex_rd"}, 64'(bus.ex_rd), 64'd0);
        chk({tag, "_ex_op_a"}, bus.ex_op_a, 64'd0);
        chk({tag, "_ex_op_b"}, bus.ex_op_b, 64'd0);
        chk({tag, "_ex_imm"}, bus.ex_imm, 64'd0);
        chk({tag, "_ex_ctrl"}, 64'(bus.ex_ctrl), 64'd0);
    endtask

    initial begin
        stim_t s;
        apply(idle());
        #1 reset = 1'b1;
        #2;
        reset_checks("por");
        chk("por_stall", 64'(bus.id_stall), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // ADD X1 then a reader of X1
        s = idle(); s.id_valid = 1; s.rd = 5'd1; s.rw = 1; step(s);
        s = idle(); s.id_valid = 1; s.rn = 5'd1; s.uses_rn = 1; s.exr = 64'h5; s.d1 = 64'h99;
        s.rd = 5'd10; s.rw = 1; step(s);
        // X31 as destination and source
        s = idle(); s.id_valid = 1; s.rd = 5'd31; s.rw = 1; step(s);
        s = idle(); s.id_valid = 1; s.rn = 5'd31; s.uses_rn = 1; s.exr = 64'h1234; s.d1 = 64'h42;
        s.rd = 5'd10; step(s);
        // LDUR X2 then a dependent reader: one bubble, then MEM forwarding
        s = idle(); s.id_valid = 1; s.rd = 5'd2; s.rw = 1; s.mr = 1; step(s);
        s = idle(); s.id_valid = 1; s.rm = 5'd2; s.uses_rm = 1; s.d2 = 64'h1; s.rd = 5'd11; s.rw = 1;
        step(s);
        s.mem_rd = 5'd2; s.mem_rw = 1; s.mem_res = 64'hDEAD; step(s);
        // WB forwarding over a stale regfile read
        s = idle(); s.id_valid = 1; s.rn = 5'd3; s.uses_rn = 1; s.d1 = 64'h11;
        s.wb_rd = 5'd3; s.wb_rw = 1; s.wb_d = 64'h77; s.rd = 5'd12; step(s);
        // EX beats MEM for X4
        s = idle(); s.id_valid = 1; s.rd = 5'd4; s.rw = 1; step(s);
        s = idle(); s.id_valid = 1; s.rn = 5'd4; s.uses_rn = 1; s.exr = 64'hA;
        s.mem_rd = 5'd4; s.mem_rw = 1; s.mem_res = 64'hB; s.rd = 5'd13; step(s);
        // flush together with a load-use hit
        s = idle(); s.id_valid = 1; s.rd = 5'd7; s.rw = 1; s.mr = 1; step(s);
        s = idle(); s.id_valid = 1; s.rn = 5'd7; s.uses_rn = 1; s.flush = 1; step(s);
        // ADD X5 then a reader draining through EX, MEM, WB
        s = idle(); s.id_valid = 1; s.rd = 5'd5; s.rw = 1; step(s);
        s = idle(); s.id_valid = 1; s.rn = 5'd5; s.uses_rn = 1; s.d1 = 64'h55; s.exr = 64'h66;
        s.rd = 5'd14; step(s);
        s.mem_rd = 5'd5; s.mem_rw = 1; s.mem_res = 64'h66; step(s);
        s.mem_rw = 0; s.wb_rd = 5'd5; s.wb_rw = 1; s.wb_d = 64'h66; step(s);
        s.wb_rw = 0; step(s);

        for (int i = 0; i < 1500; i++) step(rnd());

        // Reset in the middle of a load-use stall
        s = idle(); s.id_valid = 1; s.rd = 5'd8; s.rw = 1; s.mr = 1; step(s);
        @(posedge clk);
        #2;
        active = 1'b0;
        @(negedge clk);
        s = idle(); s.id_valid = 1; s.rn = 5'd8; s.uses_rn = 1; s.rd = 5'd9;
        apply(s);
        #1;
        chk("pre_rst_stall", 64'(bus.id_stall), 64'(waits(s.rn, s.uses_rn, s)));
        #2 reset = 1'b1;
        #1;
        reset_checks("mid");
        chk("mid_stall_dep", 64'(bus.id_stall), 64'd0);
        bus.id_valid = 1'b0;
        #1;
        chk("mid_stall_idle", 64'(bus.id_stall), 64'd0);
        @(posedge clk);
        #1;
        chk("held_ex_valid", 64'(bus.ex_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        ex_q.delete();
        stall_q.delete();
        m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0; m_rd = 5'd0;
        @(posedge clk);
        #1;
        chk("post_rst_bubble", 64'(bus.ex_valid), 64'd0);

        for (int i = 0; i < 400; i++) step(rnd());
        @(posedge clk);
        #3;
        active = 1'b0;
        if (ex_q.size() != 0 || stall_q.size() != 0) chk("queues_drained", 64'd1, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
